model_vector_strength_multiplier: RTL and testbench

Streaming element-wise fixed-point multiplier that sits directly downstream of the vector oneplus stage in the NTM content-addressing path. It pairs the key-strength stream (oneplus output, stream A) with the cosine-similarity stream (stream B) element by element and emits their product. Each input has a small FIFO that absorbs the skew between the two producers. A 2-stage multiply pipeline gives one result per cycle.

---
 rtl/model_vector_strength_multiplier.sv | 133 +++++++++++++
 tb/tb_model_vector_strength_multiplier.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/model_vector_strength_multiplier.sv
// model_vector_strength_multiplier: streaming element-wise Q(DATA_SIZE-FRACTION_SIZE).FRACTION_SIZE multiply of key strength (A) by similarity (B)
// Ports: CLK/RST (async, active-high); START + SIZE_IN begin a vector, READY pulses at its end;
//        DATA_A_IN/DATA_B_IN with their enables feed two skew FIFOs; DATA_OUT/DATA_OUT_ENABLE carry products;
//        ERROR is the sticky full-FIFO drop flag. Define MODEL_VECTOR_STRENGTH_SATURATION_EN to clamp instead of wrap.
module model_vector_strength_multiplier #(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_A_IN_ENABLE,
  input  logic                 DATA_B_IN_ENABLE,
  output logic                 DATA_OUT_ENABLE,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  localparam int D = DATA_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {STARTER, RUN, ENDER} state_t;
  state_t state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_q, in_a_q, in_b_q, issue_q, out_cnt_q, out_cnt_d;
  logic [D-1:0] mem_a_q [FIFO_DEPTH];
  logic [D-1:0] mem_b_q [FIFO_DEPTH];
  logic [AW-1:0] wp_a_q, rp_a_q, wp_b_q, rp_b_q;
  logic [AW:0] cnt_a_q, cnt_b_q;
  logic [D-1:0] op_a_q, op_b_q, dout_q, result;
  logic op_v_q, prod_v_q, dout_en_q, ready_q, error_q;
  logic signed [2*D-1:0] prod_q, shifted;
  logic start, acc_a, acc_b, wr_a, wr_b, ovf, pop, ready_d;
  assign READY = ready_q;
  assign DATA_OUT_ENABLE = dout_en_q;
  assign DATA_OUT = dout_q;
  assign ERROR = error_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state_q <= STARTER;
    else state_q <= state_d;
  // RUN ends on the same edge that emits the final product, so READY lands one cycle later
  always_comb
    state_d = state_q == STARTER ? (START ? (SIZE_IN == '0 ? ENDER : RUN) : STARTER) :
              state_q == RUN ? (out_cnt_d == size_q ? ENDER : RUN) : STARTER;
  always_comb begin
    start = state_q == STARTER && START;
    acc_a = state_q == RUN && DATA_A_IN_ENABLE && in_a_q < size_q;
    acc_b = state_q == RUN && DATA_B_IN_ENABLE && in_b_q < size_q;
    wr_a = acc_a && cnt_a_q != FULL;
    wr_b = acc_b && cnt_b_q != FULL;
    ovf = (acc_a && cnt_a_q == FULL) || (acc_b && cnt_b_q == FULL);
    pop = state_q == RUN && cnt_a_q != '0 && cnt_b_q != '0 && issue_q < size_q;
    out_cnt_d = out_cnt_q + CONTROL_SIZE'(prod_v_q);
    ready_d = state_q == ENDER;
  end
  always_comb begin
    shifted = prod_q >>> FRACTION_SIZE;
`ifdef MODEL_VECTOR_STRENGTH_SATURATION_EN
    result = (&shifted[2*D-1:D-1] || ~|shifted[2*D-1:D-1]) ? shifted[D-1:0] :
             {shifted[2*D-1], {(D-1){~shifted[2*D-1]}}};
`else
    result = D'(shifted);
`endif
  end
  always_ff @(posedge CLK) begin
    if (wr_a) mem_a_q[wp_a_q] <= DATA_A_IN;
    if (wr_b) mem_b_q[wp_b_q] <= DATA_B_IN;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      size_q <= '0;
      in_a_q <= '0;
      in_b_q <= '0;
      issue_q <= '0;
      out_cnt_q <= '0;
      wp_a_q <= '0;
      rp_a_q <= '0;
      cnt_a_q <= '0;
      wp_b_q <= '0;
      rp_b_q <= '0;
      cnt_b_q <= '0;
      error_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_v_q <= 1'b0;
      prod_q <= '0;
      prod_v_q <= 1'b0;
      dout_q <= '0;
      dout_en_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (start) begin
        size_q <= CONTROL_SIZE'(SIZE_IN);
        in_a_q <= '0;
        in_b_q <= '0;
        issue_q <= '0;
        out_cnt_q <= '0;
        wp_a_q <= '0;
        rp_a_q <= '0;
        cnt_a_q <= '0;
        wp_b_q <= '0;
        rp_b_q <= '0;
        cnt_b_q <= '0;
        error_q <= 1'b0;
      end else begin
        in_a_q <= in_a_q + CONTROL_SIZE'(wr_a);
        in_b_q <= in_b_q + CONTROL_SIZE'(wr_b);
        issue_q <= issue_q + CONTROL_SIZE'(pop);
        out_cnt_q <= out_cnt_d;
        wp_a_q <= wp_a_q + AW'(wr_a);
        rp_a_q <= rp_a_q + AW'(pop);
        cnt_a_q <= cnt_a_q + (AW+1)'(wr_a) - (AW+1)'(pop);
        wp_b_q <= wp_b_q + AW'(wr_b);
        rp_b_q <= rp_b_q + AW'(pop);
        cnt_b_q <= cnt_b_q + (AW+1)'(wr_b) - (AW+1)'(pop);
        error_q <= error_q | ovf;
      end
      op_v_q <= pop;
      if (pop) begin
        op_a_q <= mem_a_q[rp_a_q];
        op_b_q <= mem_b_q[rp_b_q];
      end
      prod_v_q <= op_v_q;
      if (op_v_q) prod_q <= {{D{op_a_q[D-1]}}, op_a_q} * {{D{op_b_q[D-1]}}, op_b_q};
      dout_en_q <= prod_v_q;
      if (prod_v_q) dout_q <= result;
      ready_q <= ready_d;
    end
endmodule

// File: tb/tb_model_vector_strength_multiplier.sv
// tb_model_vector_strength_multiplier: directed and randomized checks of the vector strength multiplier
module tb_model_vector_strength_multiplier;
  logic CLK, RST, START, READY, DATA_A_IN_ENABLE, DATA_B_IN_ENABLE, DATA_OUT_ENABLE, ERROR;
  logic [63:0] SIZE_IN, DATA_A_IN, DATA_B_IN, DATA_OUT;
  int total = 0, bad = 0, cyc = 0, n_ready = 0, ready_at = -1;
  logic [63:0] got[$];
  int out_at[$];
  logic [63:0] ma[$], mb[$], exp_q[$];
  logic [63:0] va[8], vb[8];
  logic [63:0] sat_exp;
  model_vector_strength_multiplier dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE), .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .ERROR(ERROR), .SIZE_IN(SIZE_IN),
    .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN), .DATA_OUT(DATA_OUT)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic logic [63:0] fx(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
    p = p >>> 32;
`ifdef MODEL_VECTOR_STRENGTH_SATURATION_EN
    if (p > 128'sh7FFF_FFFF_FFFF_FFFF) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (p < -128'sh8000_0000_0000_0000) return 64'h8000_0000_0000_0000;
`endif
    return p[63:0];
  endfunction
  function automatic logic [63:0] gv(input int i);
    return i < got.size() ? got[i] : 64'bx;
  endfunction
  function automatic int oa(input int i);
    return i < out_at.size() ? out_at[i] : -1;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic cycle(input logic ea, input logic [63:0] a, input logic eb, input logic [63:0] b);
    DATA_A_IN_ENABLE = ea;
    DATA_A_IN = a;
    DATA_B_IN_ENABLE = eb;
    DATA_B_IN = b;
    @(posedge CLK);
    #1;
    cyc++;
    if (DATA_OUT_ENABLE) begin
      got.push_back(DATA_OUT);
      out_at.push_back(cyc);
    end
    if (READY) begin
      n_ready++;
      ready_at = cyc;
    end
  endtask
  task automatic clr();
    got.delete();
    out_at.delete();
    cyc = 0;
    n_ready = 0;
    ready_at = -1;
  endtask
  task automatic do_start(input logic [63:0] s);
    SIZE_IN = s;
    START = 1'b1;
    cycle(0, 0, 0, 0);
    START = 1'b0;
    clr();
  endtask
  task automatic rst_pulse();
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask
  initial begin
    RST = 1'b1;
    START = 1'b0;
    SIZE_IN = '0;
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
    DATA_A_IN = '0;
    DATA_B_IN = '0;
    #3;
    chk("rst_ready", 64'(READY), 0);
    chk("rst_den", 64'(DATA_OUT_ENABLE), 0);
    chk("rst_dout", DATA_OUT, 0);
    chk("rst_err", 64'(ERROR), 0);
    #9;
    RST = 1'b0;
    // basic product, B lagging A by two cycles
    do_start(3);
    cycle(1, 64'h2_0000_0000, 0, 0);
    cycle(1, 64'h1_0000_0000, 0, 0);
    cycle(1, 64'h3_8000_0000, 1, 64'h1_8000_0000);
    cycle(0, 0, 1, 64'hFFFF_FFFF_8000_0000);
    cycle(0, 0, 1, 64'h2_0000_0000);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    chk("basic_n", 64'(got.size()), 3);
    chk("basic_v0", gv(0), 64'h3_0000_0000);
    chk("basic_v1", gv(1), 64'hFFFF_FFFF_8000_0000);
    chk("basic_v2", gv(2), 64'h7_0000_0000);
    chk("basic_first_at", 64'(oa(0)), 6);
    chk("basic_ready_at", 64'(ready_at), 64'(oa(2) + 1));
    chk("basic_nready", 64'(n_ready), 1);
    chk("basic_err", 64'(ERROR), 0);
    // back-to-back, both streams every cycle
    do_start(8);
    for (int i = 0; i < 8; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
      cycle(1, va[i], 1, vb[i]);
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    chk("b2b_n", 64'(got.size()), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("b2b_v%0d", i), gv(i), fx(va[i], vb[i]));
    chk("b2b_first_at", 64'(oa(0)), 4);
    chk("b2b_last_at", 64'(oa(7)), 11);
    chk("b2b_ready_at", 64'(ready_at), 12);
    chk("b2b_nready", 64'(n_ready), 1);
    // zero length
    do_start(0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    chk("zero_ready_at", 64'(ready_at), 1);
    chk("zero_nready", 64'(n_ready), 1);
    chk("zero_n", 64'(got.size()), 0);
    // START during RUN is ignored
    do_start(2);
    va[0] = 64'h5_0000_0000; vb[0] = 64'h0_4000_0000;
    va[1] = 64'hFFFF_FFFD_0000_0000; vb[1] = 64'h2_8000_0000;
    cycle(1, va[0], 1, vb[0]);
    SIZE_IN = 0;
    START = 1'b1;
    cycle(1, va[1], 1, vb[1]);
    START = 1'b0;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    chk("ign_n", 64'(got.size()), 2);
    chk("ign_v0", gv(0), 64'h1_4000_0000);
    chk("ign_v1", gv(1), 64'hFFFF_FFF8_8000_0000);
    chk("ign_nready", 64'(n_ready), 1);
    // saturation / wrap
    do_start(1);
    cycle(1, 64'h7FFF_0000_0000_0000, 1, 64'h4_0000_0000);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
`ifdef MODEL_VECTOR_STRENGTH_SATURATION_EN
    sat_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    sat_exp = 64'hFFFC_0000_0000_0000;
`endif
    chk("sat_v", gv(0), sat_exp);
    chk("sat_at", 64'(oa(0)), 4);
    chk("sat_nready", 64'(n_ready), 1);
    // overflow drop
    do_start(6);
    for (int i = 0; i < 5; i++) begin
      va[i] = {$urandom, $urandom};
      cycle(1, va[i], 0, 0);
      if (i == 3) chk("ovf_err_before", 64'(ERROR), 0);
    end
    chk("ovf_err_after", 64'(ERROR), 1);
    for (int i = 0; i < 6; i++) begin
      vb[i] = {$urandom, $urandom};
      cycle(0, 0, 1, vb[i]);
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    chk("ovf_n", 64'(got.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_v%0d", i), gv(i), fx(va[i], vb[i]));
    chk("ovf_nready", 64'(n_ready), 0);
    chk("ovf_err_sticky", 64'(ERROR), 1);
    // reset mid-vector
    rst_pulse();
    do_start(4);
    for (int i = 0; i < 4; i++) cycle(1, 64'h3_0000_0000, 1, 64'h2_0000_0000);
    cycle(0, 0, 0, 0);
    chk("mid_n", 64'(got.size()), 2);
    RST = 1'b1;
    #1;
    chk("mid_den", 64'(DATA_OUT_ENABLE), 0);
    chk("mid_dout", DATA_OUT, 0);
    chk("mid_ready", 64'(READY), 0);
    chk("mid_err", 64'(ERROR), 0);
    #1;
    RST = 1'b0;
    do_start(1);
    cycle(1, 64'h1_0000_0000, 1, 64'h1_0000_0000);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    chk("post_n", 64'(got.size()), 1);
    chk("post_v", gv(0), 64'h1_0000_0000);
    chk("post_nready", 64'(n_ready), 1);
    // randomized vectors against a queue-level model
    for (int v = 0; v < 8; v++) begin
      int sz, pa, pb, na, nb, sa, sb, in_a, in_b, issued;
      logic ea, eb, pop, merr;
      logic [63:0] da, db;
      sz = $urandom_range(1, 10);
      pa = $urandom_range(1, 4);
      pb = $urandom_range(1, 4);
      na = sz + $urandom_range(0, 2);
      nb = sz + $urandom_range(0, 2);
      sa = 0; sb = 0; in_a = 0; in_b = 0; issued = 0; merr = 1'b0;
      ma.delete(); mb.delete(); exp_q.delete();
      do_start(64'(sz));
      for (int c = 0; c < 70; c++) begin
        ea = c < 55 && sa < na && $urandom_range(1, 4) <= pa;
        eb = c < 55 && sb < nb && $urandom_range(1, 4) <= pb;
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        sa += int'(ea);
        sb += int'(eb);
        pop = ma.size() > 0 && mb.size() > 0 && issued < sz;
        if (ea && in_a < sz) begin
          if (ma.size() == 4) merr = 1'b1;
          else begin ma.push_back(da); in_a++; end
        end
        if (eb && in_b < sz) begin
          if (mb.size() == 4) merr = 1'b1;
          else begin mb.push_back(db); in_b++; end
        end
        if (pop) begin
          exp_q.push_back(fx(ma.pop_front(), mb.pop_front()));
          issued++;
        end
        cycle(ea, da, eb, db);
      end
      chk($sformatf("rnd%0d_n", v), 64'(got.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) chk($sformatf("rnd%0d_v%0d", v, k), gv(k), exp_q[k]);
      chk($sformatf("rnd%0d_nready", v), 64'(n_ready), 64'(exp_q.size() == sz));
      chk($sformatf("rnd%0d_err", v), 64'(ERROR), 64'(merr));
      rst_pulse();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
